bidir_bus_turnaround: RTL and testbench

Controller-side stage that owns the A side of a bidirectional board-delay wire (DQ-style bus). Arbitrates write and read requests onto one shared tristate bus. Enforces idle turnaround cycles whenever bus direction changes, drives write data, and samples read data a fixed latency after each read request. Sits directly upstream of the wire-delay model in the memory-interface simulation benches.

---
 rtl/bidir_bus_turnaround_if.sv | 25 ++
 rtl/bidir_bus_turnaround.sv | 123 ++++++++++++
 tb/tb_bidir_bus_turnaround.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bidir_bus_turnaround_if.sv
// Handshake and status bundle for the bidirectional bus turnaround controller.
// The requester uses the master modport and the controller uses the slave modport.
interface bidir_bus_turnaround_if #(
  parameter int WIDTH = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic             rd_data_valid;
  logic [WIDTH-1:0] rd_data;
  logic             pad_oe;
  logic             bus_dir;

  modport master (
    output wr_valid, wr_data, rd_req_valid,
    input  wr_ready, rd_req_ready, rd_data_valid, rd_data, pad_oe, bus_dir
  );

  modport slave (
    input  wr_valid, wr_data, rd_req_valid,
    output wr_ready, rd_req_ready, rd_data_valid, rd_data, pad_oe, bus_dir
  );
endinterface

// File: rtl/bidir_bus_turnaround.sv
// Controller-side owner of a shared tristate DQ-style bus: arbitrates writes and reads,
// inserts idle turnaround cycles on direction changes and samples read data at fixed latency.
module bidir_bus_turnaround #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int RD_LATENCY  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  bidir_bus_turnaround_if.slave    bus,
  inout  wire  [WIDTH-1:0]         pad_io
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_gap_cnt;
  logic [4:0]       r_lat_cnt;
  logic             r_bus_dir;
  logic [WIDTH-1:0] r_wr_data;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_data_valid;

  logic w_pad_oe;
  logic w_rd_outstanding;
  logic w_sample;
  logic w_released;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_wr_ready;
  logic w_rd_ready;
  logic w_wr_accept;
  logic w_rd_accept;

  // A cycle that is itself driving the bus never counts as released, even if the
  // gap counter still holds its saturated value from before this write burst.
  always_comb begin
    w_next_state     = r_state;
    w_pad_oe         = (r_state == ST_DRIVE);
    w_rd_outstanding = (r_state == ST_RD_WAIT);
    w_sample         = w_rd_outstanding && (r_lat_cnt == 5'd1);
    w_released       = (r_gap_cnt >= 4'(TURN_CYCLES)) && !w_pad_oe;
    w_wr_elig        = r_bus_dir || w_released;
    w_rd_elig        = !r_bus_dir || w_released;
    w_wr_ready       = !reset && !w_rd_outstanding && w_wr_elig &&
                       !(bus.rd_req_valid && r_bus_dir);
    w_wr_accept      = bus.wr_valid && w_wr_ready;
    w_rd_ready       = !reset && !w_rd_outstanding && w_rd_elig &&
                       !(bus.wr_valid && !r_bus_dir) && !w_wr_accept;
    w_rd_accept      = bus.rd_req_valid && w_rd_ready;

    case (r_state)
      ST_IDLE, ST_DRIVE: begin
        if (w_wr_accept) begin
          w_next_state = ST_DRIVE;
        end else if (w_rd_accept) begin
          w_next_state = ST_RD_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (w_sample) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_gap_cnt       <= 4'(TURN_CYCLES);
      r_lat_cnt       <= 5'd0;
      r_bus_dir       <= 1'b1;
      r_wr_data       <= '0;
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_wr_accept) begin
        r_wr_data <= bus.wr_data;
        r_bus_dir <= 1'b1;
      end else if (w_rd_accept) begin
        r_bus_dir <= 1'b0;
      end

      if (w_rd_accept) begin
        r_lat_cnt <= 5'(RD_LATENCY);
      end else if (w_rd_outstanding && (r_lat_cnt != 5'd0)) begin
        r_lat_cnt <= r_lat_cnt - 5'd1;
      end

      // Any cycle that used the bus restarts the turnaround gap.
      if (w_pad_oe || w_sample) begin
        r_gap_cnt <= 4'd0;
      end else if (r_gap_cnt < 4'(TURN_CYCLES)) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end

      r_rd_data_valid <= w_sample;
      if (w_sample) begin
        r_rd_data <= pad_io;
      end
    end
  end

  assign pad_io            = w_pad_oe ? r_wr_data : {WIDTH{1'bz}};
  assign bus.pad_oe        = w_pad_oe;
  assign bus.bus_dir       = r_bus_dir;
  assign bus.wr_ready      = w_wr_ready;
  assign bus.rd_req_ready  = w_rd_ready;
  assign bus.rd_data_valid = r_rd_data_valid;
  assign bus.rd_data       = r_rd_data;

endmodule

// File: tb/tb_bidir_bus_turnaround.sv
// Bench for bidir_bus_turnaround: directed and random traffic checked against a
// cycle-indexed model of grants, turnaround gaps and read latency, plus a short TURN=1/LAT=1 run.
module tb_bidir_bus_turnaround;

  localparam int WIDTH  = 8;
  localparam int TURN_A = 2;
  localparam int LAT_A  = 4;
  localparam int TURN_B = 1;
  localparam int LAT_B  = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bidir_bus_turnaround_if #(.WIDTH(WIDTH)) busA ();
  bidir_bus_turnaround_if #(.WIDTH(WIDTH)) busB ();

  wire  [WIDTH-1:0] padA;
  wire  [WIDTH-1:0] padB;
  logic             bDriveA;
  logic [WIDTH-1:0] bDataA;
  logic             bDriveB;
  logic [WIDTH-1:0] bDataB;

  assign padA = bDriveA ? bDataA : {WIDTH{1'bz}};
  assign padB = bDriveB ? bDataB : {WIDTH{1'bz}};

  bidir_bus_turnaround #(.WIDTH(WIDTH), .TURN_CYCLES(TURN_A), .RD_LATENCY(LAT_A)) dutA (
    .clk    (clk),
    .reset  (reset),
    .bus    (busA.slave),
    .pad_io (padA)
  );

  bidir_bus_turnaround #(.WIDTH(WIDTH), .TURN_CYCLES(TURN_B), .RD_LATENCY(LAT_B)) dutB (
    .clk    (clk),
    .reset  (reset),
    .bus    (busB.slave),
    .pad_io (padB)
  );

  int checks = 0;
  int errors = 0;

  // Model state is kept as absolute cycle numbers rather than counters.
  int         cyc;
  int         lastActive;
  int         rdSample;
  int         wrDriveCycle;
  int         rdValidCycle;
  int         obsGrant;
  logic       dirM;
  logic [7:0] wrDriveData;
  logic [7:0] rdWord;
  logic [7:0] nextRdWord;
  logic [7:0] expRdData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    lastActive   = -1000;
    rdSample     = -1;
    wrDriveCycle = -1;
    rdValidCycle = -1;
    dirM         = 1'b1;
    expRdData    = 8'h00;
  endtask

  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rv);
    logic outM, relM, wrReadyE, wrAccE, rdReadyE;
    busA.wr_valid     = wv;
    busA.wr_data      = wd;
    busA.rd_req_valid = rv;
    bDriveA           = (cyc == rdSample);
    bDataA            = rdWord;
    #1;
    outM     = (rdSample >= cyc);
    relM     = ((cyc - lastActive - 1) >= TURN_A);
    wrReadyE = !outM && (dirM || relM) && !(rv && dirM);
    wrAccE   = wv && wrReadyE;
    rdReadyE = !outM && (!dirM || relM) && !(wv && !dirM) && !wrAccE;
    checkOutput("wr_ready", 32'(busA.wr_ready), 32'(wrReadyE));
    checkOutput("rd_req_ready", 32'(busA.rd_req_ready), 32'(rdReadyE));
    checkOutput("pad_oe", 32'(busA.pad_oe), 32'(wrDriveCycle == cyc));
    if (wrDriveCycle == cyc) checkOutput("pad_io", 32'(padA), 32'(wrDriveData));
    checkOutput("bus_dir", 32'(busA.bus_dir), 32'(dirM));
    checkOutput("rd_data_valid", 32'(busA.rd_data_valid), 32'(rdValidCycle == cyc));
    checkOutput("rd_data", 32'(busA.rd_data), 32'(expRdData));
    checkOutput("contention", 32'(busA.pad_oe && bDriveA), 32'd0);
    obsGrant = (wv && busA.wr_ready) ? 1 : ((rv && busA.rd_req_ready) ? 2 : 0);
    @(posedge clk);
    if (cyc == rdSample) begin
      expRdData    = rdWord;
      rdValidCycle = cyc + 1;
    end
    if (wrAccE) begin
      wrDriveCycle = cyc + 1;
      wrDriveData  = wd;
      dirM         = 1'b1;
      lastActive   = cyc + 1;
    end else if (rv && rdReadyE) begin
      rdSample   = cyc + LAT_A;
      rdWord     = nextRdWord;
      nextRdWord = 8'($urandom);
      dirM       = 1'b0;
      lastActive = cyc + LAT_A;
    end
    #1;
    cyc++;
  endtask

  // Reset is raised mid-cycle so its effect on the outputs is seen before any edge.
  task automatic pulseReset();
    busA.wr_valid = 1'b0; busA.rd_req_valid = 1'b0; busA.wr_data = 8'h00;
    busB.wr_valid = 1'b0; busB.rd_req_valid = 1'b0; busB.wr_data = 8'h00;
    bDriveA = 1'b0;
    bDriveB = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_pad_oe", 32'(busA.pad_oe), 32'd0);
    checkOutput("rst_wr_ready", 32'(busA.wr_ready), 32'd0);
    checkOutput("rst_rd_req_ready", 32'(busA.rd_req_ready), 32'd0);
    checkOutput("rst_rd_data_valid", 32'(busA.rd_data_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(busA.rd_data), 32'd0);
    checkOutput("rst_bus_dir", 32'(busA.bus_dir), 32'd1);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  initial begin
    int prevGrant;
    reset = 1'b1;
    busA.wr_valid = 1'b0; busA.rd_req_valid = 1'b0; busA.wr_data = 8'h00;
    busB.wr_valid = 1'b0; busB.rd_req_valid = 1'b0; busB.wr_data = 8'h00;
    bDriveA = 1'b0; bDataA = 8'h00;
    bDriveB = 1'b0; bDataB = 8'h00;
    cyc = 0;
    rdWord = 8'h00;
    wrDriveData = 8'h00;
    obsGrant = 0;
    nextRdWord = 8'h3C;
    modelReset();
    @(posedge clk);
    #1;

    $display("[TB] reset and single write 0xA5");
    pulseReset();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] back-to-back writes");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] write then held read request");
    applyStimulus(1'b1, 8'h77, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (7) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rd_data_3c", 32'(busA.rd_data), 32'h3C);

    $display("[TB] both directions requested continuously");
    pulseReset();
    prevGrant = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      if (obsGrant != 0) begin
        if (prevGrant != 0) checkOutput("alternate", 32'(obsGrant), (prevGrant == 1) ? 32'd2 : 32'd1);
        prevGrant = obsGrant;
      end
    end
    checkOutput("alternate_progress", 32'(prevGrant != 0), 32'd1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] reset during outstanding read");
    pulseReset();
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    pulseReset();
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] reset during write drive");
    applyStimulus(1'b1, 8'hC3, 1'b0);
    #1;
    checkOutput("pre_rst_pad_oe", 32'(busA.pad_oe), 32'd1);
    pulseReset();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] random traffic");
    repeat (400) applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 4));
    repeat (10) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] TURN_CYCLES=1 RD_LATENCY=1 instance");
    pulseReset();
    busB.wr_valid = 1'b1; busB.wr_data = 8'h96; busB.rd_req_valid = 1'b1;
    #1;
    checkOutput("b_rd_req_ready", 32'(busB.rd_req_ready), 32'd1);
    checkOutput("b_wr_ready_blocked", 32'(busB.wr_ready), 32'd0);
    @(posedge clk); #1;
    busB.rd_req_valid = 1'b0;
    bDriveB = 1'b1; bDataB = 8'h5A;
    #1;
    checkOutput("b_outstanding_rd_ready", 32'(busB.rd_req_ready), 32'd0);
    checkOutput("b_outstanding_wr_ready", 32'(busB.wr_ready), 32'd0);
    checkOutput("b_outstanding_pad_oe", 32'(busB.pad_oe), 32'd0);
    @(posedge clk); #1;
    bDriveB = 1'b0;
    #1;
    checkOutput("b_rd_data_valid", 32'(busB.rd_data_valid), 32'd1);
    checkOutput("b_rd_data", 32'(busB.rd_data), 32'h5A);
    checkOutput("b_turn_wr_ready", 32'(busB.wr_ready), 32'd0);
    @(posedge clk); #1;
    #1;
    checkOutput("b_wr_ready", 32'(busB.wr_ready), 32'd1);
    checkOutput("b_rd_data_valid_off", 32'(busB.rd_data_valid), 32'd0);
    @(posedge clk); #1;
    busB.wr_valid = 1'b0;
    #1;
    checkOutput("b_pad_oe", 32'(busB.pad_oe), 32'd1);
    checkOutput("b_pad_io", 32'(padB), 32'h96);
    checkOutput("b_bus_dir", 32'(busB.bus_dir), 32'd1);
    checkOutput("b_contention", 32'(busB.pad_oe && bDriveB), 32'd0);
    @(posedge clk); #1;
    #1;
    checkOutput("b_pad_oe_off", 32'(busB.pad_oe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
